// File: rtl/serial_subtractor4.sv
// serial_subtractor4: bit-serial a - b - bin on one full-subtractor slice, LSB first.
// Latency: WIDTH cycles from the accept edge to done; one operation per WIDTH+2 cycles.
// Backpressure: start is accepted only in IDLE; start while busy is ignored.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, a, b, bin  request plus operands, all sampled together in IDLE
//   busy              high in RUN and DONE
//   done              one-cycle pulse when diff/bout (and ovf) are valid
//   diff, bout        a - b - bin mod 2^WIDTH and the unsigned borrow out
//   ovf               signed-overflow flag, present only with SUB_OVERFLOW_EN
//
// Optional feature macro: SUB_OVERFLOW_EN adds the ovf output.

module serial_subtractor4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_accept;
    logic               w_last;
    logic               w_busy;
    logic               w_done;

    logic               w_x;
    logic               w_y;
    logic               w_d;
    logic               w_borrow_nxt;
    logic [WIDTH-1:0]   w_res_nxt;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // 1-bit full-subtractor slice on the operand LSBs
    // ------------------------------------------------------------------
    assign w_x          = r_a[0];
    assign w_y          = r_b[0];
    assign w_d          = w_x ^ w_y ^ r_borrow;
    assign w_borrow_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Operand shifters, borrow flop and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_res    <= '0;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_res    <= w_res_nxt;
            r_borrow <= w_borrow_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Visible results: loaded only on the edge that completes the last
    // bit, so the outputs never expose a partially assembled difference.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_last) begin
            r_diff <= w_res_nxt;
            r_bout <= w_borrow_nxt;
        end
    end

`ifdef SUB_OVERFLOW_EN
    // On the last bit the slice inputs are exactly the latched operand MSBs
    // and w_d is the result MSB, so no extra MSB registers are needed.
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (w_x != w_y) && (w_d != w_x);
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = w_busy;
    assign done = w_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor4.sv
module tb_serial_subtractor4;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;
`endif

    int n_vec;
    int n_miss;

    // Expected values of the held outputs (last completed operation).
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bout;
    logic             exp_ovf;

    serial_subtractor4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the (WIDTH+1)-bit two's complement of a - b - bin, via integers.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin);
        int r;
        logic [WIDTH:0] t;
        r = int'(ma) - int'(mb) - int'(mbin);
        t = r[WIDTH:0];
        exp_diff = t[WIDTH-1:0];
        exp_bout = t[WIDTH];
        exp_ovf  = (ma[WIDTH-1] != mb[WIDTH-1]) && (exp_diff[WIDTH-1] != ma[WIDTH-1]);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check({tag, "_bout"}, 32'(bout), 32'(exp_bout));
`ifdef SUB_OVERFLOW_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // One framed operation starting from IDLE at a sample point.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tbin, input string tag);
        int cyc;
        int busy_cnt;
        bit seen;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        tick();                      // accept edge
        start = 1'b0;
        a     = WIDTH'($urandom);    // operands may change after the accept edge
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
        cyc      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (cyc < 20) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            // Before done the outputs still show the previous result.
            check({tag, "_hold"}, 32'({bout, diff}), 32'({exp_bout, exp_diff}));
            tick();
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
        model(ta, tb_v, tbin);
        check_held(tag);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_len"}, 32'(busy_cnt + (busy ? 1 : 0)), 32'(WIDTH + 1));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check_held({tag, "_after"});
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        exp_diff = '0;
        exp_bout = 1'b0;
        exp_ovf  = 1'b0;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_held("rst");
        rst_n = 1'b1;
        tick();

        // Load a nonzero result first so the async reset clearing is visible.
        do_op(4'd3, 4'd2, 1'b0, "t2_3m2");

        // Asynchronous reset in the middle of RUN
        start = 1'b1; a = 4'd9; b = 4'd4; bin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t1_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_diff = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
        check("t1_busy_async", 32'(busy), 32'd0);
        check("t1_done_async", 32'(done), 32'd0);
        check_held("t1_async");
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_no_done", 32'(done), 32'd0);
            check("t1_no_busy", 32'(busy), 32'd0);
        end

        // Directed cases
        do_op(4'd3,  4'd2,  1'b0, "t2_again");
        do_op(4'd2,  4'd3,  1'b0, "t3_2m3");
        do_op(4'd5,  4'd3,  1'b1, "t3_5m3b");
        do_op(4'd0,  4'd0,  1'b1, "t4_0m0b");
        do_op(4'd15, 4'd15, 1'b0, "t4_15m15");
        do_op(4'd8,  4'd1,  1'b0, "t6_8m1");
        do_op(4'd7,  4'd15, 1'b0, "t6_7m15");
        do_op(4'd5,  4'd3,  1'b0, "t6_5m3");

        // Start while busy is ignored; then start held high runs back-to-back
        // at one operation per WIDTH+2 cycles.
        start = 1'b1; a = 4'd12; b = 4'd5; bin = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3 * (WIDTH + 2); c++) begin
            if (c == 2) begin
                start = 1'b1; a = 4'd7; b = 4'd1; bin = 1'b0;
            end
            if (c == WIDTH) model(4'd12, 4'd5, 1'b0);
            else if (c == 2 * WIDTH + 2) model(4'd7, 4'd1, 1'b0);
            check("t5_done", 32'(done), 32'((c % (WIDTH + 2)) == WIDTH));
            check("t5_busy", 32'(busy), 32'((c % (WIDTH + 2)) != WIDTH + 1));
            check_held("t5");
            if (c == 3 * (WIDTH + 2) - 1) start = 1'b0;
            tick();
        end
        // The final cycle above ended in IDLE with start low, so the bench is idle now.
        check("t5_idle", 32'(busy), 32'd0);

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 24; k++) begin
            do_op(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
